// File: rtl/filt_frame_scheduler.sv
// rtl/filt_frame_scheduler.sv - two-bank frame scheduler between producer, filter engine and consumer
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   prod_req            producer asks for a free bank
//   prod_grant/index    bank granted to the producer, held until prod_done
//   prod_done           one-cycle pulse, producer finished the granted bank
//   filt_start/index    start request and bank number for the filter engine
//   filt_idle           filter engine idle
//   cons_valid/index    filtered bank offered to the consumer, held until cons_done
//   cons_done           one-cycle pulse, consumer finished reading
//   frames_filtered     completed filter runs, wraps
//   start_timeout       sticky: filt_start left unaccepted for idle_timeout cycles
module filt_frame_scheduler #(
    parameter int idle_timeout = 65535,
    parameter int cnt_w        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             prod_req,
    output logic             prod_grant,
    output logic             prod_index,
    input  logic             prod_done,
    output logic             filt_start,
    output logic             filt_index,
    input  logic             filt_idle,
    output logic             cons_valid,
    output logic             cons_index,
    input  logic             cons_done,
    output logic [cnt_w-1:0] frames_filtered,
    output logic             start_timeout
);

    localparam int TW = (idle_timeout < 2) ? 1 : $clog2(idle_timeout + 1);

    typedef enum logic [2:0] {
        B_FREE,
        B_FILLING,
        B_READY,
        B_FILTERING,
        B_FILTERED,
        B_READING
    } bank_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_ARM,
        F_RUN
    } fstate_t;

    bank_t            bank_q [2];
    bank_t            bank_d [2];
    fstate_t          fstate_q, fstate_d;
    logic             prod_grant_q, prod_grant_d;
    logic             prod_index_q, prod_index_d;
    logic             grant_pref_q, grant_pref_d;
    logic             filt_start_q, filt_start_d;
    logic             filt_index_q, filt_index_d;
    logic             ready_first_q, ready_first_d;
    logic             cons_valid_q, cons_valid_d;
    logic             cons_index_q, cons_index_d;
    logic             filtered_first_q, filtered_first_d;
    logic [cnt_w-1:0] frames_q, frames_d;
    logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic             start_timeout_q, start_timeout_d;

    logic             gsel;
    logic             fsel;
    logic             csel;

    always_comb begin
        bank_d[0]        = bank_q[0];
        bank_d[1]        = bank_q[1];
        fstate_d         = fstate_q;
        prod_grant_d     = prod_grant_q;
        prod_index_d     = prod_index_q;
        grant_pref_d     = grant_pref_q;
        filt_start_d     = filt_start_q;
        filt_index_d     = filt_index_q;
        ready_first_d    = ready_first_q;
        cons_valid_d     = cons_valid_q;
        cons_index_d     = cons_index_q;
        filtered_first_d = filtered_first_q;
        frames_d         = frames_q;
        tmo_cnt_d        = tmo_cnt_q;
        start_timeout_d  = start_timeout_q;
        gsel             = 1'b0;
        fsel             = 1'b0;
        csel             = 1'b0;

        // Every decision below looks at bank_q, so a bank changed this cycle
        // (e.g. freed by cons_done) is only visible to the others next cycle.
        // Each bank is in exactly one state, so at most one of these
        // transitions can touch a given bank in a cycle.

        // Producer side
        if (prod_grant_q && prod_done) begin
            bank_d[prod_index_q] = B_READY;
            prod_grant_d         = 1'b0;
        end else if (!prod_grant_q && prod_req &&
                     (bank_q[0] == B_FREE || bank_q[1] == B_FREE)) begin
            if (bank_q[0] == B_FREE && bank_q[1] == B_FREE) begin
                gsel = grant_pref_q;
            end else begin
                gsel = (bank_q[1] == B_FREE);
            end
            bank_d[gsel] = B_FILLING;
            prod_grant_d = 1'b1;
            prod_index_d = gsel;
            grant_pref_d = ~gsel;
        end

        // Filter engine handshake
        case (fstate_q)
            F_IDLE: begin
                if (filt_idle && (bank_q[0] == B_READY || bank_q[1] == B_READY)) begin
                    if (bank_q[0] == B_READY && bank_q[1] == B_READY) begin
                        fsel = ready_first_q;
                    end else begin
                        fsel = (bank_q[1] == B_READY);
                    end
                    bank_d[fsel] = B_FILTERING;
                    filt_index_d = fsel;
                    filt_start_d = 1'b1;
                    fstate_d     = F_ARM;
                end
            end
            F_ARM: begin
                if (!filt_idle) begin
                    filt_start_d = 1'b0;
                    tmo_cnt_d    = '0;
                    fstate_d     = F_RUN;
                end else begin
                    // Counter saturates so the flag cannot be re-armed by wrap.
                    if (tmo_cnt_q != TW'(idle_timeout)) begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                    if (tmo_cnt_q == TW'(idle_timeout - 1)) begin
                        start_timeout_d = 1'b1;
                    end
                end
            end
            F_RUN: begin
                if (filt_idle) begin
                    bank_d[filt_index_q] = B_FILTERED;
                    frames_d             = frames_q + 1'b1;
                    fstate_d             = F_IDLE;
                end
            end
            default: begin
                fstate_d = F_IDLE;
            end
        endcase

        // Consumer side
        if (cons_valid_q && cons_done) begin
            bank_d[cons_index_q] = B_FREE;
            cons_valid_d         = 1'b0;
        end else if (!cons_valid_q &&
                     (bank_q[0] == B_FILTERED || bank_q[1] == B_FILTERED)) begin
            if (bank_q[0] == B_FILTERED && bank_q[1] == B_FILTERED) begin
                csel = filtered_first_q;
            end else begin
                csel = (bank_q[1] == B_FILTERED);
            end
            bank_d[csel] = B_READING;
            cons_valid_d = 1'b1;
            cons_index_d = csel;
        end

        // Age trackers: a bank entering READY/FILTERED becomes the oldest
        // only if the other bank is not already waiting in that state.
        for (int b = 0; b < 2; b++) begin
            if (bank_q[b] != B_READY && bank_d[b] == B_READY &&
                bank_d[1-b] != B_READY) begin
                ready_first_d = 1'(b);
            end
            if (bank_q[b] != B_FILTERED && bank_d[b] == B_FILTERED &&
                bank_d[1-b] != B_FILTERED) begin
                filtered_first_d = 1'(b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q[0]        <= B_FREE;
            bank_q[1]        <= B_FREE;
            fstate_q         <= F_IDLE;
            prod_grant_q     <= 1'b0;
            prod_index_q     <= 1'b0;
            grant_pref_q     <= 1'b0;
            filt_start_q     <= 1'b0;
            filt_index_q     <= 1'b0;
            ready_first_q    <= 1'b0;
            cons_valid_q     <= 1'b0;
            cons_index_q     <= 1'b0;
            filtered_first_q <= 1'b0;
            frames_q         <= '0;
            tmo_cnt_q        <= '0;
            start_timeout_q  <= 1'b0;
        end else begin
            bank_q[0]        <= bank_d[0];
            bank_q[1]        <= bank_d[1];
            fstate_q         <= fstate_d;
            prod_grant_q     <= prod_grant_d;
            prod_index_q     <= prod_index_d;
            grant_pref_q     <= grant_pref_d;
            filt_start_q     <= filt_start_d;
            filt_index_q     <= filt_index_d;
            ready_first_q    <= ready_first_d;
            cons_valid_q     <= cons_valid_d;
            cons_index_q     <= cons_index_d;
            filtered_first_q <= filtered_first_d;
            frames_q         <= frames_d;
            tmo_cnt_q        <= tmo_cnt_d;
            start_timeout_q  <= start_timeout_d;
        end
    end

    assign prod_grant      = prod_grant_q;
    assign prod_index      = prod_index_q;
    assign filt_start      = filt_start_q;
    assign filt_index      = filt_index_q;
    assign cons_valid      = cons_valid_q;
    assign cons_index      = cons_index_q;
    assign frames_filtered = frames_q;
    assign start_timeout   = start_timeout_q;

endmodule
